// File: rtl/rv32_clint_pkg.sv
// Shared definitions for the core-local interruptor: register offsets,
// decoded register selector and the byte-enable merge helper.
package rv32_clint_pkg;

    localparam logic [15:0] CLINT_MSIP        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_MSIP,
        SEL_MTIMECMP_LO,
        SEL_MTIMECMP_HI,
        SEL_MTIME_LO,
        SEL_MTIME_HI
    } reg_sel_e;

    // Merge a write into an existing word, one byte lane per enable bit.
    function automatic logic [31:0] apply_be(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] merged;
        merged = old;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/rv32_clint_if.sv
// Single-cycle peripheral bus as seen by the CLINT.
interface rv32_clint_if #(
    parameter int unsigned ADDR_W = 16
) ();

    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_be;
    logic [31:0]       bus_wdata;
    logic              bus_ack;
    logic [31:0]       bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_be,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_be,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata
    );

endinterface

// File: rtl/rv32_clint_prescaler.sv
// mtime prescaler: one tick every PRESCALE clock cycles.
module rv32_clint_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Counting down from PRESCALE-1 to 0 gives the same tick phase as an
    // up-count 0..PRESCALE-1 that ticks at the top: first tick PRESCALE-1
    // cycles after reset, then every PRESCALE cycles.
    assign tick = (count_q == '0);

    // Next count: reload on tick, otherwise decrement.
    always_comb begin
        count_d = tick ? RELOAD : (count_q - 1'b1);
    end

    // Free-running counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= RELOAD;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rv32_clint.sv
// Core-local interruptor: machine timer (mtime/mtimecmp) and software
// interrupt (msip) registers behind the single-cycle peripheral bus.
module rv32_clint
    import rv32_clint_pkg::*;
#(
    parameter int unsigned PRESCALE       = 1,
    parameter int unsigned ADDR_W         = 16,
    parameter logic [63:0] RESET_MTIMECMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    rv32_clint_if.slave       bus,
    output logic              irq_software,
    output logic              irq_timer
);

    localparam logic [ADDR_W-1:0] A_MSIP        = ADDR_W'(CLINT_MSIP);
    localparam logic [ADDR_W-1:0] A_MTIMECMP_LO = ADDR_W'(CLINT_MTIMECMP_LO);
    localparam logic [ADDR_W-1:0] A_MTIMECMP_HI = ADDR_W'(CLINT_MTIMECMP_HI);
    localparam logic [ADDR_W-1:0] A_MTIME_LO    = ADDR_W'(CLINT_MTIME_LO);
    localparam logic [ADDR_W-1:0] A_MTIME_HI    = ADDR_W'(CLINT_MTIME_HI);

    logic        tick;
    reg_sel_e    sel;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] msip_word;

    logic [63:0] mtime_q,      mtime_d;
    logic [63:0] mtimecmp_q,   mtimecmp_d;
    logic        msip_q,       msip_d;
    logic        ack_q,        ack_d;
    logic [31:0] rdata_q,      rdata_d;
    logic        irq_timer_q,  irq_timer_d;

    // Address bits [1:0] carry no information on a word-aligned bus.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.bus_addr[1:0];

    rv32_clint_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign wr_en = bus.bus_req &  bus.bus_we;
    assign rd_en = bus.bus_req & ~bus.bus_we;

    // Word-address decode of the register map; anything else is unmapped.
    always_comb begin
        sel = SEL_NONE;
        if (bus.bus_addr[ADDR_W-1:2] == A_MSIP[ADDR_W-1:2]) begin
            sel = SEL_MSIP;
        end else if (bus.bus_addr[ADDR_W-1:2] == A_MTIMECMP_LO[ADDR_W-1:2]) begin
            sel = SEL_MTIMECMP_LO;
        end else if (bus.bus_addr[ADDR_W-1:2] == A_MTIMECMP_HI[ADDR_W-1:2]) begin
            sel = SEL_MTIMECMP_HI;
        end else if (bus.bus_addr[ADDR_W-1:2] == A_MTIME_LO[ADDR_W-1:2]) begin
            sel = SEL_MTIME_LO;
        end else if (bus.bus_addr[ADDR_W-1:2] == A_MTIME_HI[ADDR_W-1:2]) begin
            sel = SEL_MTIME_HI;
        end
    end

    // Register next-state: tick increment, overridden by any bus write.
    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        msip_word  = apply_be({31'b0, msip_q}, bus.bus_wdata, bus.bus_be);

        if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end

        // A write to either mtime half replaces the whole next value, so the
        // tick increment (and its carry) is dropped for that cycle.
        if (wr_en) begin
            case (sel)
                SEL_MSIP:        msip_d = msip_word[0];
                SEL_MTIMECMP_LO: mtimecmp_d[31:0]  = apply_be(mtimecmp_q[31:0],
                                                              bus.bus_wdata, bus.bus_be);
                SEL_MTIMECMP_HI: mtimecmp_d[63:32] = apply_be(mtimecmp_q[63:32],
                                                              bus.bus_wdata, bus.bus_be);
                SEL_MTIME_LO:    mtime_d = {mtime_q[63:32],
                                            apply_be(mtime_q[31:0], bus.bus_wdata, bus.bus_be)};
                SEL_MTIME_HI:    mtime_d = {apply_be(mtime_q[63:32], bus.bus_wdata, bus.bus_be),
                                            mtime_q[31:0]};
                default:         ;
            endcase
        end
    end

    // Bus response next-state: ack every request, read data from current state.
    always_comb begin
        ack_d   = bus.bus_req;
        rdata_d = '0;
        if (rd_en) begin
            case (sel)
                SEL_MSIP:        rdata_d = {31'b0, msip_q};
                SEL_MTIMECMP_LO: rdata_d = mtimecmp_q[31:0];
                SEL_MTIMECMP_HI: rdata_d = mtimecmp_q[63:32];
                SEL_MTIME_LO:    rdata_d = mtime_q[31:0];
                SEL_MTIME_HI:    rdata_d = mtime_q[63:32];
                default:         rdata_d = '0;
            endcase
        end
    end

    // Timer comparator on the current register values.
    always_comb begin
        irq_timer_d = (mtime_q >= mtimecmp_q);
    end

    // State, response and interrupt registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q     <= '0;
            mtimecmp_q  <= RESET_MTIMECMP;
            msip_q      <= 1'b0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
            irq_timer_q <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            irq_timer_q <= irq_timer_d;
        end
    end

    assign bus.bus_ack   = ack_q;
    assign bus.bus_rdata = rdata_q;
    assign irq_software  = msip_q;
    assign irq_timer     = irq_timer_q;

endmodule
